// File: rtl/pipe_skid_nop.sv
// pipe_skid_nop: two-entry registered skid buffer that shows a NOP bubble when empty
module pipe_skid_nop #(
  parameter int BitWidth = 32,
  parameter logic [BitWidth-1:0] NOP = BitWidth'(32'h0000_0013)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [BitWidth-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic [BitWidth-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  output logic [1:0]          count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_n;
  logic [BitWidth-1:0] skid, main_n, skid_n;
  logic in_fire, out_fire;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  always_comb begin
    state_n = state;
    main_n = out_data;
    skid_n = skid;
    case (state)
      EMPTY: begin
        state_n = in_fire ? ONE : EMPTY;
        main_n = in_fire ? in_data : NOP;
      end
      ONE: begin
        if (in_fire && !out_fire) begin
          state_n = FULL;
          skid_n = in_data;
        end else if (out_fire && !in_fire) begin
          state_n = EMPTY;
          main_n = NOP;
        end else if (in_fire) begin
          main_n = in_data;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_n = ONE;
          main_n = skid;
          skid_n = NOP;
        end
      end
      default: begin
        state_n = EMPTY;
        main_n = NOP;
        skid_n = NOP;
      end
    endcase
    if (flush) begin
      state_n = EMPTY;
      main_n = NOP;
      skid_n = NOP;
    end
  end
  // handshake outputs are registered from the next state so nothing is combinational to the ports
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
      out_data <= NOP;
      skid <= NOP;
      out_valid <= 1'b0;
      in_ready <= 1'b1;
      count <= 2'd0;
    end else begin
      state <= state_n;
      out_data <= main_n;
      skid <= skid_n;
      out_valid <= state_n != EMPTY;
      in_ready <= state_n != FULL;
      count <= state_n == FULL ? 2'd2 : state_n == ONE ? 2'd1 : 2'd0;
    end
  end
endmodule

// File: tb/tb_pipe_skid_nop.sv
// tb_pipe_skid_nop: scoreboard bench; stimulus queues accepted entries, monitor checks outputs each cycle
module tb_pipe_skid_nop;
  localparam int W = 32;
  localparam logic [W-1:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b0, out_ready = 1'b0, in_valid = 1'b0, flush = 1'b0;
  logic out_valid, in_ready;
  logic [W-1:0] in_data = '0, out_data;
  logic [1:0] count;
  int checks = 0, failures = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] exp_q[$];
  pipe_skid_nop #(.BitWidth(W), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, logic [W-1:0] a, logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  // exp_q holds exactly the entries the block should currently be holding, oldest first
  always @(negedge clk) begin
    int n;
    if (mon_en) begin
      n = exp_q.size();
      chk("out_valid", W'(out_valid), W'(n > 0));
      chk("count", W'(count), W'(n));
      chk("in_ready", W'(in_ready), W'(n < 2));
      chk("out_data", out_data, n > 0 ? exp_q[0] : NOP);
      if (n > 0 && out_ready) void'(exp_q.pop_front());
    end
  end
  task automatic step(bit r, bit iv, logic [W-1:0] d, bit ordy, bit fl);
    bit acc;
    rst = r;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    flush = fl;
    acc = iv && exp_q.size() < 2;
    #6;
    if (!r || fl) exp_q.delete();
    else if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, $urandom, 1'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'hA000_0000 + i, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hCCCC_0003, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'hAAAA_0011, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hBBBB_0012, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hCCCC_0013, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'hAAAA_0021, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hDDDD_0022, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h1111_0031, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h2222_0032, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h3333_0033, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 10000; i++)
      step(($urandom % 256) != 0, ($urandom % 10) < 7, $urandom, ($urandom % 10) < 6, ($urandom % 16) == 0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_skid_nop.md
PIPE_SKID_NOP -- requirements
Module: pipe_skid_nop

Interface
REQ-001 Parameter BitWidth, default 32, width of the data path.
REQ-002 Parameter NOP, default 32'h0000_0013, bubble value driven on out_data whenever no valid entry is presented.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 out_data  output  BitWidth  downstream data; equals NOP when out_valid=0.
REQ-006 out_valid  output  1  downstream entry present.
REQ-007 out_ready  input  1  downstream accepts this cycle.
REQ-008 in_data  input  BitWidth  upstream data.
REQ-009 in_valid  input  1  upstream entry offered.
REQ-010 in_ready  output  1  block can accept; registered, equals NOT FULL.
REQ-011 flush  input  1  discard all held entries (branch/exception squash).
REQ-012 count  output  2  occupancy: 0, 1 or 2.

Function
REQ-013 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-014 Storage: main register (drives out_data) plus one skid register; all outputs come directly from flops, with no combinational path from inputs to outputs.
REQ-015 States: EMPTY (count 0, out_valid 0), ONE (count 1, out_valid 1, in_ready 1), FULL (count 2, out_valid 1, in_ready 0).
REQ-016 EMPTY: in_fire -> ONE, main=in_data; else stay EMPTY, main=NOP.
REQ-017 ONE: in_fire & !out_fire -> FULL, skid=in_data, main held; out_fire & !in_fire -> EMPTY, main=NOP; in_fire & out_fire -> ONE, main=in_data; neither -> hold.
REQ-018 FULL: out_fire -> ONE, main=skid, skid=NOP; else hold both; in_valid is ignored (in_ready=0).
REQ-019 Hold rule: while out_valid=1 and out_ready=0, out_data shall not change.
REQ-020 Ordering: entries leave in acceptance order; no entry is duplicated or dropped except by flush or reset.
REQ-021 Latency: an entry accepted in EMPTY appears on out_data/out_valid the cycle after in_fire.
REQ-022 Throughput: one entry per cycle sustained when out_ready=1 continuously.
REQ-023 flush=1 (rst high): next state EMPTY, main=NOP, skid=NOP, out_valid=0, count=0, in_ready=1; any in_fire that cycle is discarded; flush overrides all transitions.
REQ-024 Idle skid register shall hold NOP.

Reset
REQ-025 rst=0 at posedge clk: state EMPTY, out_data=NOP, out_valid=0, count=0, in_ready=1, skid=NOP.
REQ-026 Reset has priority over flush and all handshakes; data offered during a reset cycle is discarded.
REQ-027 Reset mid-operation (ONE or FULL) discards all held entries within one cycle.

Verification
REQ-028 Reset: rst=0 for 5 cycles with random in_data, in_valid=1 -> out_data=32'h0000_0013, out_valid=0, count=0, in_ready=1 each cycle.
REQ-029 Pass-through: rst=1, out_ready=1, in_valid=1, in_data=A,B,C on consecutive cycles -> out_data=A,B,C one cycle later each, count=1 throughout.
REQ-030 Back-pressure: out_ready=0, push A then B -> count=2, in_ready=0, out_data=A held; C offered is ignored; raise out_ready -> A then B, then out_valid=0, out_data=NOP.
REQ-031 Flush: FULL with A,B, assert flush with in_valid=1, in_data=C -> next cycle count=0, out_valid=0, out_data=NOP; C never appears.
REQ-032 Simultaneous: ONE holding A, in_fire with D and out_fire same cycle -> next cycle out_data=D, count=1.
REQ-033 Random: 10k cycles of random in_valid/out_ready/flush against a queue model -> output sequence matches; out_data=NOP whenever out_valid=0.
